// File: rtl/ddr2_init_refresh_seq.sv
// DDR2 power-up initialisation and periodic auto-refresh sequencer.
// Owns the DRAM command bus through the JEDEC init sequence, then borrows it back from the
// front-end scheduler (ref_req / ref_grant) whenever one or more refreshes are pending.
// Every command is registered and driven for one cycle; a command issued at cycle n is
// followed by the next one at cycle n + T_x, where T_x belongs to the command just issued.
module ddr2_init_refresh_seq #(
    parameter int unsigned CS_BITS   = 1,
    parameter int unsigned BA_BITS   = 3,
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned T_PWRUP   = 40000,
    parameter int unsigned T_CKE_HI  = 80,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned T_RFC     = 26,
    parameter int unsigned T_DLLK    = 200,
    parameter int unsigned T_REFI    = 1560,
    parameter int unsigned INIT_REFS = 2,
    parameter int unsigned MAX_PEND  = 8,
    parameter logic [ADDR_BITS-1:0] MR_VAL   = 14'h0432,
    parameter logic [ADDR_BITS-1:0] EMR1_VAL = 14'h0000,
    parameter int unsigned OCD_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [CS_BITS-1:0]   cke,
    output logic [CS_BITS-1:0]   cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic [CS_BITS-1:0]   odt,
    output logic                 seq_owns_bus,
    output logic                 init_done,
    output logic                 ref_req,
    input  logic                 ref_grant,
    output logic                 ref_overflow
);

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;

    // Each init state names the command that issues once the wait counter reaches zero
    localparam logic [3:0] StPwrup   = 4'd0;
    localparam logic [3:0] StPre1    = 4'd1;
    localparam logic [3:0] StEmr2    = 4'd2;
    localparam logic [3:0] StEmr3    = 4'd3;
    localparam logic [3:0] StEmr1    = 4'd4;
    localparam logic [3:0] StMrDll   = 4'd5;
    localparam logic [3:0] StPre2    = 4'd6;
    localparam logic [3:0] StRefInit = 4'd7;
    localparam logic [3:0] StMr      = 4'd8;
    localparam logic [3:0] StOcdDef  = 4'd9;
    localparam logic [3:0] StOcdExit = 4'd10;
    localparam logic [3:0] StDllWait = 4'd11;
    localparam logic [3:0] StIdle    = 4'd12;
    localparam logic [3:0] StRefRef  = 4'd13;
    localparam logic [3:0] StRefChk  = 4'd14;

    // Wait reloads are T_x - 1 so the next command lands exactly T_x cycles later; 0 acts as 1
    localparam logic [CNT_W-1:0] TM_PWRUP  = (T_PWRUP  > 1) ? CNT_W'(T_PWRUP  - 1) : '0;
    localparam logic [CNT_W-1:0] TM_CKE_HI = (T_CKE_HI > 1) ? CNT_W'(T_CKE_HI - 1) : '0;
    localparam logic [CNT_W-1:0] TM_RP     = (T_RP     > 1) ? CNT_W'(T_RP     - 1) : '0;
    localparam logic [CNT_W-1:0] TM_MRD    = (T_MRD    > 1) ? CNT_W'(T_MRD    - 1) : '0;
    localparam logic [CNT_W-1:0] TM_RFC    = (T_RFC    > 1) ? CNT_W'(T_RFC    - 1) : '0;
    localparam logic [CNT_W-1:0] TM_DLLK   = (T_DLLK   > 1) ? CNT_W'(T_DLLK   - 1) : '0;
    localparam logic [CNT_W-1:0] TM_REFI   = (T_REFI   > 1) ? CNT_W'(T_REFI   - 1) : '0;
    localparam logic [CNT_W-1:0] LAST_REF  = (INIT_REFS > 1) ? CNT_W'(INIT_REFS - 1) : '0;

    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    localparam logic [ADDR_BITS-1:0] A0_MASK  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A8_MASK  = ADDR_BITS'(256);
    localparam logic [ADDR_BITS-1:0] A10_MASK = ADDR_BITS'(1024);
    localparam logic [ADDR_BITS-1:0] OCD_MASK = ADDR_BITS'(896);  // A9:A7

    // EMR1 with A0 cleared keeps the DLL enabled
    localparam logic [ADDR_BITS-1:0] EMR1_DLL = EMR1_VAL & ~A0_MASK;

    logic [3:0]           state_q, state_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]     dll_q, dll_d;
    logic [CNT_W-1:0]     refi_q, refi_d;
    logic [CNT_W-1:0]     refs_q, refs_d;
    logic [PEND_W-1:0]    pending_q, pending_d;
    logic                 cke_q, cke_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [BA_BITS-1:0]   ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 owns_q, owns_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic go;
    logic expire;
    logic dec;
    logic ref_req_w;

    assign ref_req_w = (pending_q != '0) && done_q;

    // Next-state: command sequencing, wait counters, refresh timer and pending-refresh count
    always_comb begin
        state_d   = state_q;
        wait_d    = (wait_q != '0) ? wait_q - CNT_W'(1) : '0;
        dll_d     = (dll_q != '0) ? dll_q - CNT_W'(1) : '0;
        refi_d    = refi_q;
        refs_d    = refs_q;
        pending_d = pending_q;
        cke_d     = cke_q;
        cmd_d     = CMD_NOP;
        ba_d      = '0;
        addr_d    = '0;
        owns_d    = owns_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        go        = (wait_q == '0);
        expire    = 1'b0;
        dec       = 1'b0;

        // Free-running tREFI timer once init has completed
        if (done_q) begin
            if (refi_q == '0) begin
                expire = 1'b1;
                refi_d = TM_REFI;
            end else begin
                refi_d = refi_q - CNT_W'(1);
            end
        end

        case (state_q)
            StPwrup: begin
                if (go) begin
                    cke_d   = 1'b1;
                    wait_d  = TM_CKE_HI;
                    state_d = StPre1;
                end
            end
            StPre1: begin
                if (go) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = A10_MASK;
                    wait_d  = TM_RP;
                    state_d = StEmr2;
                end
            end
            StEmr2: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    ba_d    = BA_BITS'(2);
                    wait_d  = TM_MRD;
                    state_d = StEmr3;
                end
            end
            StEmr3: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    ba_d    = BA_BITS'(3);
                    wait_d  = TM_MRD;
                    state_d = StEmr1;
                end
            end
            StEmr1: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_DLL;
                    wait_d  = TM_MRD;
                    state_d = StMrDll;
                end
            end
            StMrDll: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    addr_d  = MR_VAL | A8_MASK;
                    wait_d  = TM_MRD;
                    dll_d   = TM_DLLK;  // DLL lock time counts from the DLL-reset MR
                    state_d = StPre2;
                end
            end
            StPre2: begin
                if (go) begin
                    cmd_d   = CMD_PRE;
                    addr_d  = A10_MASK;
                    wait_d  = TM_RP;
                    refs_d  = '0;
                    state_d = StRefInit;
                end
            end
            StRefInit: begin
                if (go) begin
                    cmd_d  = CMD_REF;
                    wait_d = TM_RFC;
                    if (refs_q == LAST_REF) begin
                        state_d = StMr;
                    end else begin
                        refs_d = refs_q + CNT_W'(1);
                    end
                end
            end
            StMr: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    addr_d  = MR_VAL & ~A8_MASK;
                    wait_d  = TM_MRD;
                    state_d = (OCD_EN != 0) ? StOcdDef : StDllWait;
                end
            end
            StOcdDef: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_DLL | OCD_MASK;
                    wait_d  = TM_MRD;
                    state_d = StOcdExit;
                end
            end
            StOcdExit: begin
                if (go) begin
                    cmd_d   = CMD_LMR;
                    ba_d    = BA_BITS'(1);
                    addr_d  = EMR1_DLL & ~OCD_MASK;
                    wait_d  = TM_MRD;
                    state_d = StDllWait;
                end
            end
            StDllWait: begin
                if (go && (dll_q == '0)) begin
                    done_d  = 1'b1;
                    owns_d  = 1'b0;
                    refi_d  = TM_REFI;
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (ref_req_w && ref_grant) begin
                    owns_d  = 1'b1;
                    cmd_d   = CMD_PRE;
                    addr_d  = A10_MASK;
                    wait_d  = TM_RP;
                    state_d = StRefRef;
                end
            end
            StRefRef: begin
                if (go) begin
                    cmd_d   = CMD_REF;
                    dec     = 1'b1;
                    wait_d  = TM_RFC;
                    state_d = StRefChk;
                end
            end
            StRefChk: begin
                if (go) begin
                    // Catch-up burst continues only while the scheduler still grants the bus
                    if ((pending_q != '0) && ref_grant) begin
                        cmd_d  = CMD_REF;
                        dec    = 1'b1;
                        wait_d = TM_RFC;
                    end else begin
                        owns_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StPwrup;
            end
        endcase

        // Coincident expiry and REF cancel out; an expiry at saturation is lost and flagged
        if (expire && !dec) begin
            if (pending_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (dec && !expire) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // State and registered command-bus outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPwrup;
            wait_q    <= TM_PWRUP;
            dll_q     <= '0;
            refi_q    <= '0;
            refs_q    <= '0;
            pending_q <= '0;
            cke_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
            owns_q    <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            dll_q     <= dll_d;
            refi_q    <= refi_d;
            refs_q    <= refs_d;
            pending_q <= pending_d;
            cke_q     <= cke_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
            owns_q    <= owns_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign cke          = {CS_BITS{cke_q}};
    assign cs_n         = {CS_BITS{~cke_q}};
    assign ras_n        = cmd_q[2];
    assign cas_n        = cmd_q[1];
    assign we_n         = cmd_q[0];
    assign ba           = ba_q;
    assign addr         = addr_q;
    assign odt          = '0;
    assign seq_owns_bus = owns_q;
    assign init_done    = done_q;
    assign ref_req      = ref_req_w;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_ddr2_init_refresh_seq.sv
// Directed bench for ddr2_init_refresh_seq with shortened timing parameters.
// Cycle n means the output value just after the n-th rising edge following reset release.
module tb_ddr2_init_refresh_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ref_grant = 1'b0;
    logic [0:0]  cke;
    logic [0:0]  cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [0:0]  odt;
    logic        seq_owns_bus;
    logic        init_done;
    logic        ref_req;
    logic        ref_overflow;
    logic [2:0]  cmd;

    int checks = 0;
    int errors = 0;
    int cyc;

    assign cmd = {ras_n, cas_n, we_n};

    ddr2_init_refresh_seq #(
        .T_PWRUP  (10),
        .T_CKE_HI (4),
        .T_RP     (3),
        .T_MRD    (2),
        .T_RFC    (6),
        .T_DLLK   (20),
        .T_REFI   (50),
        .OCD_EN   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cke          (cke),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .ba           (ba),
        .addr         (addr),
        .odt          (odt),
        .seq_owns_bus (seq_owns_bus),
        .init_done    (init_done),
        .ref_req      (ref_req),
        .ref_grant    (ref_grant),
        .ref_overflow (ref_overflow)
    );

    always #5 clk = ~clk;

    // Cycle counter relative to reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance to 1 time unit after edge n; a missed target counts as a failure
    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (cyc != n) begin
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({cke, cs_n, cmd, ba, addr, odt} !== {1'b0, 1'b1, 3'b111, 3'd0, 14'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_bus: got %b required %b", {cke, cs_n, cmd, ba, addr, odt},
                     {1'b0, 1'b1, 3'b111, 3'd0, 14'h0, 1'b0});
        end
        checks++;
        if ({seq_owns_bus, init_done, ref_req, ref_overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: got %b required 1000",
                     {seq_owns_bus, init_done, ref_req, ref_overflow});
        end
    endtask

    // Full init sequence; ref_grant held high to show it is ignored before init_done
    task automatic test_init();
        int          cy[11] = '{14, 17, 19, 21, 23, 25, 28, 34, 40, 42, 44};
        logic [2:0]  ec[11] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001,
                                3'b001, 3'b000, 3'b000, 3'b000};
        logic [2:0]  eb[11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
        logic [13:0] ea[11] = '{14'h0400, 14'h0, 14'h0, 14'h0, 14'h0532, 14'h0400, 14'h0,
                                14'h0, 14'h0432, 14'h0380, 14'h0000};
        do_reset();
        ref_grant = 1'b1;
        wait_cyc(9);
        checks++;
        if ({cke, cs_n} !== 2'b01) begin
            errors++;
            $display("FAIL pwrup_cke_low: got cke/cs_n %b required 01", {cke, cs_n});
        end
        wait_cyc(10);
        checks++;
        if ({cke, cs_n, cmd} !== 5'b10111) begin
            errors++;
            $display("FAIL cke_rise: got cke/cs_n/cmd %b required 10111", {cke, cs_n, cmd});
        end
        for (int i = 0; i < 11; i++) begin
            wait_cyc(cy[i] - 1);
            checks++;
            if ({cs_n, cmd} !== 4'b0111) begin
                errors++;
                $display("FAIL init_gap_%0d: cycle %0d got cs_n/cmd %b required 0111",
                         i, cyc, {cs_n, cmd});
            end
            wait_cyc(cy[i]);
            checks++;
            if ({seq_owns_bus, cs_n, cmd, ba, addr} !== {1'b1, 1'b0, ec[i], eb[i], ea[i]}) begin
                errors++;
                $display("FAIL init_cmd_%0d: cycle %0d got cmd %b ba %0d addr %h own %b, required cmd %b ba %0d addr %h own 1",
                         i, cyc, cmd, ba, addr, seq_owns_bus, ec[i], eb[i], ea[i]);
            end
        end
        wait_cyc(45);
        checks++;
        if ({init_done, seq_owns_bus} !== 2'b01) begin
            errors++;
            $display("FAIL init_early: got done/own %b required 01", {init_done, seq_owns_bus});
        end
        wait_cyc(46);
        checks++;
        if ({init_done, seq_owns_bus, ref_req, cmd} !== 6'b100111) begin
            errors++;
            $display("FAIL init_done: got done/own/req/cmd %b required 100111",
                     {init_done, seq_owns_bus, ref_req, cmd});
        end
    endtask

    // Continues from test_init with ref_grant high; third round drops grant after PRE
    task automatic test_periodic();
        int base;
        for (int k = 0; k < 3; k++) begin
            base = 96 + 50 * k;
            wait_cyc(base - 1);
            checks++;
            if ({ref_req, seq_owns_bus} !== 2'b00) begin
                errors++;
                $display("FAIL per%0d_pre_expiry: got req/own %b required 00", k,
                         {ref_req, seq_owns_bus});
            end
            wait_cyc(base);
            checks++;
            if ({ref_req, seq_owns_bus} !== 2'b10) begin
                errors++;
                $display("FAIL per%0d_expiry: got req/own %b required 10", k,
                         {ref_req, seq_owns_bus});
            end
            wait_cyc(base + 1);
            checks++;
            if ({seq_owns_bus, cmd, addr} !== {1'b1, 3'b010, 14'h0400}) begin
                errors++;
                $display("FAIL per%0d_pre: got own %b cmd %b addr %h required 1 010 0400", k,
                         seq_owns_bus, cmd, addr);
            end
            if (k == 2) ref_grant = 1'b0;
            wait_cyc(base + 3);
            checks++;
            if (cmd !== 3'b111) begin
                errors++;
                $display("FAIL per%0d_trp_gap: got cmd %b required 111", k, cmd);
            end
            wait_cyc(base + 4);
            checks++;
            if ({cmd, ref_req} !== 4'b0010) begin
                errors++;
                $display("FAIL per%0d_ref: got cmd/req %b required 0010", k, {cmd, ref_req});
            end
            wait_cyc(base + 9);
            checks++;
            if (seq_owns_bus !== 1'b1) begin
                errors++;
                $display("FAIL per%0d_trfc_hold: got own %b required 1", k, seq_owns_bus);
            end
            wait_cyc(base + 10);
            checks++;
            if ({seq_owns_bus, cmd} !== 4'b0111) begin
                errors++;
                $display("FAIL per%0d_release: got own/cmd %b required 0111", k,
                         {seq_owns_bus, cmd});
            end
        end
        ref_grant = 1'b0;
    endtask

    // Five postponed refreshes drained as PRE plus five back-to-back REFs
    task automatic test_burst();
        do_reset();
        ref_grant = 1'b0;
        wait_cyc(299);
        checks++;
        if ({ref_req, seq_owns_bus} !== 2'b10) begin
            errors++;
            $display("FAIL burst_wait: got req/own %b required 10", {ref_req, seq_owns_bus});
        end
        ref_grant = 1'b1;
        wait_cyc(300);
        checks++;
        if ({seq_owns_bus, cmd} !== 4'b1010) begin
            errors++;
            $display("FAIL burst_pre: got own/cmd %b required 1010", {seq_owns_bus, cmd});
        end
        for (int j = 0; j < 5; j++) begin
            wait_cyc(302 + 6 * j);
            checks++;
            if (cmd !== 3'b111) begin
                errors++;
                $display("FAIL burst_gap_%0d: got cmd %b required 111", j, cmd);
            end
            wait_cyc(303 + 6 * j);
            checks++;
            if ({seq_owns_bus, cmd} !== 4'b1001) begin
                errors++;
                $display("FAIL burst_ref_%0d: got own/cmd %b required 1001", j,
                         {seq_owns_bus, cmd});
            end
            checks++;
            if (ref_req !== (j < 4)) begin
                errors++;
                $display("FAIL burst_req_%0d: got %b required %b", j, ref_req, (j < 4));
            end
        end
        wait_cyc(333);
        checks++;
        if ({seq_owns_bus, cmd, ref_overflow} !== 5'b01110) begin
            errors++;
            $display("FAIL burst_end: got own/cmd/ovf %b required 01110",
                     {seq_owns_bus, cmd, ref_overflow});
        end
        ref_grant = 1'b0;
    endtask

    // Grant timed so the first REF lands on the second timer expiry (cycle 146)
    task automatic test_coincident();
        do_reset();
        ref_grant = 1'b0;
        wait_cyc(142);
        ref_grant = 1'b1;
        wait_cyc(143);
        checks++;
        if (cmd !== 3'b010) begin
            errors++;
            $display("FAIL coin_pre: got cmd %b required 010", cmd);
        end
        wait_cyc(146);
        checks++;
        if ({cmd, ref_req} !== 4'b0011) begin
            errors++;
            $display("FAIL coin_ref: got cmd/req %b required 0011", {cmd, ref_req});
        end
        wait_cyc(152);
        checks++;
        if ({cmd, ref_req} !== 4'b0010) begin
            errors++;
            $display("FAIL coin_second_ref: got cmd/req %b required 0010", {cmd, ref_req});
        end
        wait_cyc(158);
        checks++;
        if ({seq_owns_bus, ref_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL coin_release: got own/ovf %b required 00", {seq_owns_bus, ref_overflow});
        end
        ref_grant = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        ref_grant = 1'b0;
        wait_cyc(446);
        checks++;
        if ({ref_req, ref_overflow} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_8th: got req/ovf %b required 10", {ref_req, ref_overflow});
        end
        wait_cyc(495);
        checks++;
        if (ref_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b required 0", ref_overflow);
        end
        wait_cyc(496);
        checks++;
        if (ref_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_9th: got %b required 1", ref_overflow);
        end
        wait_cyc(600);
        ref_grant = 1'b1;
        wait_cyc(700);
        checks++;
        if (ref_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b required 1", ref_overflow);
        end
        ref_grant = 1'b0;
    endtask

    // Reset during the wait after EMR1 must clear outputs with no clock edge
    task automatic test_mid_reset();
        do_reset();
        wait_cyc(22);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cke, cs_n, cmd, ba, addr, seq_owns_bus, init_done} !==
            {1'b0, 1'b1, 3'b111, 3'd0, 14'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_async: got %b required %b",
                     {cke, cs_n, cmd, ba, addr, seq_owns_bus, init_done},
                     {1'b0, 1'b1, 3'b111, 3'd0, 14'h0, 1'b1, 1'b0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(9);
        checks++;
        if (cke !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pwrup: got cke %b required 0", cke);
        end
        wait_cyc(10);
        checks++;
        if (cke !== 1'b1) begin
            errors++;
            $display("FAIL midrst_cke: got cke %b required 1", cke);
        end
        wait_cyc(14);
        checks++;
        if (cmd !== 3'b010) begin
            errors++;
            $display("FAIL midrst_pre: got cmd %b required 010", cmd);
        end
        wait_cyc(17);
        checks++;
        if ({cmd, ba} !== 6'b000010) begin
            errors++;
            $display("FAIL midrst_emr2: got cmd/ba %b required 000010", {cmd, ba});
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_periodic();
        test_burst();
        test_coincident();
        test_overflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
